// File: rtl/eframe_pkg.sv
// eframe_pkg: shared types and constants for the energy frame transmitter.
// The frame length follows the EFRAME_CHECKSUM_EN build macro.
package eframe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    // One start bit, eight data bits and one stop bit per byte.
    localparam int unsigned BIT_PERIODS_PER_BYTE = 10;

    localparam int unsigned FRAME_BYTES_CSUM        = 3;
    localparam int unsigned FRAME_BYTES_NOCSUM      = 2;
    localparam int unsigned FRAME_BIT_PERIODS_CSUM  = FRAME_BYTES_CSUM * BIT_PERIODS_PER_BYTE;
    localparam int unsigned FRAME_BIT_PERIODS_NOCSUM = FRAME_BYTES_NOCSUM * BIT_PERIODS_PER_BYTE;

`ifdef EFRAME_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = FRAME_BYTES_CSUM;
`else
    localparam int unsigned FRAME_BYTES = FRAME_BYTES_NOCSUM;
`endif

    // Checksum is a plain 8-bit sum; the carry out is dropped.
    function automatic logic [7:0] frame_checksum(input logic [7:0] header,
                                                  input logic [7:0] sample);
        return header + sample;
    endfunction

endpackage

// File: rtl/eframe_baud_tick.sv
// eframe_baud_tick: bit-period counter producing a one-cycle tick at the
// last clock of every bit period. Cleared when a frame starts.
module eframe_baud_tick
#(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = run && (cnt_q == CNT_LAST);

    // Count clocks within the current bit period, wrapping at the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state in clocked blocks uses <= so every flop samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/energy_frame_tx.sv
// energy_frame_tx: sends one UART 8N1 frame (header, sample[, checksum])
// per accepted sample. Build macro EFRAME_CHECKSUM_EN appends the checksum
// byte; without it the frame is header and sample only.
module energy_frame_tx
    import eframe_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       tx_out,
    output logic       busy
);

    localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

    state_t     state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [1:0] byte_q, byte_d;
    logic [7:0] sample_q;
    logic [7:0] frame_byte;
    logic       tx_q, tx_d;
    logic       accept;
    logic       running;
    logic       tick;

    // Ready is held low while reset is asserted, so it can only rise once
    // the block is out of reset and idle.
    assign sample_ready = rst_n && ena && (state_q == ST_IDLE);
    assign accept       = sample_valid && sample_ready;
    assign running      = (state_q != ST_IDLE);
    assign busy         = running;
    assign tx_out       = tx_q;

    eframe_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .run   (running),
        .tick  (tick)
    );

    // Next-state logic: walk start, data and stop bits for each frame byte.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    bit_d   = '0;
                    byte_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_START;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Select the byte being sent in the coming cycle.
    always_comb begin
        frame_byte = HEADER_BYTE;
        case (byte_d)
            2'd1:    frame_byte = sample_q;
`ifdef EFRAME_CHECKSUM_EN
            2'd2:    frame_byte = frame_checksum(HEADER_BYTE, sample_q);
`endif
            default: frame_byte = HEADER_BYTE;
        endcase
    end

    // Line level for the coming cycle; registered so tx_out is glitch-free.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = frame_byte[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // State, indices, captured sample and line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            byte_q   <= '0;
            sample_q <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            if (accept) sample_q <= sample_in;
        end
    end

endmodule

// File: tb/tb_energy_frame_tx.sv
// tb_energy_frame_tx: directed frames decoded from the serial line plus a
// randomized run, all compared every cycle against a waveform-queue model.
module tb_energy_frame_tx;

    localparam int unsigned N   = 4;
    localparam logic [7:0]  HDR = 8'hA5;
`ifdef EFRAME_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b1;
    logic       ena          = 1'b0;
    logic [7:0] sample_in    = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       tx_out;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;
    bit rec_en   = 1'b0;
    bit exp_q[$];
    bit line_q[$];

    energy_frame_tx #(
        .CLKS_PER_BIT (N),
        .HEADER_BYTE  (HDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .tx_out       (tx_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is the per-cycle line waveform of its bytes.
    task automatic push_frame(input logic [7:0] s);
        logic [7:0] bytes [3];
        bytes[0] = HDR;
        bytes[1] = s;
        bytes[2] = 8'((HDR + s) % 256);
        for (int j = 0; j < NB; j++) begin
            repeat (N) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (N) exp_q.push_back(bytes[j][i]);
            repeat (N) exp_q.push_back(1'b1);
        end
    endtask

    // Model advance: one waveform entry per clock; accept only when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    exp_q.delete();
        else if (exp_q.size() != 0)    void'(exp_q.pop_front());
        else if (ena && sample_valid)  push_frame(sample_in);
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_tx;
            exp_tx = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
            check("tx_out", tx_out, exp_tx);
            check("busy", busy, exp_q.size() != 0);
            check("sample_ready", sample_ready, rst_n && ena && (exp_q.size() == 0));
        end
    end

    // Record the line while busy for offline decoding.
    always @(negedge clk) begin
        if (rec_en && busy) line_q.push_back(tx_out);
    end

    // Send one frame; optionally glitch sample_valid or drop ena mid-frame.
    task automatic run_frame(input logic [7:0] s, input int glitch_at,
                             input int ena_drop_at, input bit release_rst);
        int k;
        line_q.delete();
        rec_en = 1'b1;
        @(negedge clk); #1;
        if (release_rst) rst_n = 1'b1;
        ena          = 1'b1;
        sample_in    = s;
        sample_valid = 1'b1;
        @(negedge clk); #1;
        sample_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
        k = 0;
        while (busy && k < 1000) begin
            sample_in    = (k == glitch_at) ? 8'hFF : 8'($urandom);
            sample_valid = (k == glitch_at);
            if (k == ena_drop_at) ena = 1'b0;
            @(negedge clk); #1;
            k++;
        end
        sample_valid = 1'b0;
        rec_en       = 1'b0;
        check("frame_timeout", busy, 1'b0);
        check("ready_at_busy_fall", sample_ready, ena);
    endtask

    // Decode recorded line at bit centres against literal byte values.
    task automatic decode_check(input string tag, input logic [7:0] e0,
                                input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp_b [3];
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        check({tag, "_busy_cycles"}, line_q.size(), NB * 10 * N);
        if (line_q.size() == NB * 10 * N) begin
            for (int j = 0; j < NB; j++) begin
                logic [7:0] b;
                int base;
                base = j * 10 * N;
                for (int i = 0; i < 8; i++) b[i] = line_q[base + (i + 1) * N + N / 2];
                check({tag, "_start"}, line_q[base + N / 2], 1'b0);
                check({tag, "_byte"}, b, exp_b[j]);
                check({tag, "_stop"}, line_q[base + 9 * N + N / 2], 1'b1);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", tx_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_ready", sample_ready, 1'b0);

        // First accept on the first edge after release.
        run_frame(8'h96, -1, -1, 1'b1);
        decode_check("f96", 8'hA5, 8'h96, 8'h3B);

        run_frame(8'h2D, -1, -1, 1'b0);
        decode_check("f2d", 8'hA5, 8'h2D, 8'hD2);

        // Sample offered mid-frame is ignored; no follow-on frame.
        run_frame(8'h96, 37, -1, 1'b0);
        decode_check("glitch", 8'hA5, 8'h96, 8'h3B);
        repeat (10) @(negedge clk);
        #1;
        check("no_second_frame", busy, 1'b0);

        // Disabled: no accept, line idle.
        ena          = 1'b0;
        sample_in    = 8'h55;
        sample_valid = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("ena0_ready", sample_ready, 1'b0);
        check("ena0_busy", busy, 1'b0);
        check("ena0_tx", tx_out, 1'b1);
        sample_valid = 1'b0;

        // ena dropped mid-frame: frame still completes.
        run_frame(8'h2D, -1, 15, 1'b0);
        decode_check("ena_drop", 8'hA5, 8'h2D, 8'hD2);

        // Asynchronous reset during the data bits of the sample byte.
        @(negedge clk); #1;
        ena          = 1'b1;
        sample_in    = 8'h96;
        sample_valid = 1'b1;
        @(negedge clk); #1;
        sample_valid = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_out, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", sample_ready, 1'b0);
        run_frame(8'h2D, -1, -1, 1'b1);
        decode_check("post_rst", 8'hA5, 8'h2D, 8'hD2);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            ena          = ($urandom_range(0, 9) != 0);
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_in    = 8'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        sample_valid = 1'b0;
        for (int w = 0; w < 200 && busy; w++) @(negedge clk);
        #1;
        check("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
